// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared widths, address field positions and command record
// for the AHB command master, the AHB-to-APB bridge and the APB slaves.
package ahb_apb_pkg;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int PSEL_HI  = 6;
    localparam int PSEL_LO  = 5;
    localparam int PADDR_HI = 4;
    localparam int PADDR_LO = 0;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/ahb_cmd_master_cmd_fifo.sv
// cmd_fifo: synchronous FIFO with full/empty flags, reset to empty.
//   clk, rst     : clock, async active-high reset
//   push, din    : write request and data (ignored when full)
//   pop, dout    : read request (ignored when empty) and head data
//   full, empty  : occupancy flags
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // the extra pointer bit distinguishes a full wrap from empty
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = wr_ptr == rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: AHB-Lite master issuing buffered read/write commands to
// the AHB-to-APB bridge, one response per completed transfer.
//   HCLK, RESET                         : clock, async active-high reset
//   cmd_valid/ready/write/addr/wdata    : command input (valid/ready)
//   rsp_valid/write/rdata               : response pulse, no backpressure
//   HSEL/HADDR/HWRITE/HREADY/HWDATA     : AHB-Lite master outputs
//   HREADYOUT, HRDATA                   : bridge ready and read data
module ahb_cmd_master
    import ahb_apb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PIPELINE   = 1
) (
    input  logic              HCLK,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic              HREADY,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA
);
    cmd_t              in_cmd, head;
    logic              full, empty, allow, accept, complete;
    logic              dp_valid, dp_write;
    logic [DATA_W-1:0] dp_wdata;

    assign in_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk  (HCLK),
        .rst  (RESET),
        .push (cmd_valid),
        .din  (in_cmd),
        .pop  (accept),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    // without pipelining, a new address phase waits until the data phase drains
    assign allow     = (PIPELINE != 0) || !dp_valid;
    assign HSEL      = !empty && allow;
    assign HADDR     = HSEL ? head.addr : '0;
    assign HWRITE    = HSEL && head.write;
    assign HREADY    = HREADYOUT;
    assign HWDATA    = (dp_valid && dp_write) ? dp_wdata : '0;
    assign cmd_ready = !full;
    assign accept    = HSEL && HREADYOUT;
    assign complete  = dp_valid && HREADYOUT;

    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            dp_valid  <= accept ? 1'b1 : (complete ? 1'b0 : dp_valid);
            dp_write  <= accept ? head.write : dp_write;
            dp_wdata  <= accept ? head.wdata : dp_wdata;
            rsp_valid <= complete;
            rsp_write <= complete && dp_write;
            rsp_rdata <= (complete && !dp_write) ? HRDATA : '0;
        end
    end
endmodule

// File: tb/tb_ahb_cmd_master.sv
module tb_ahb_cmd_master;
    import ahb_apb_pkg::*;

    logic              HCLK = 0, RESET = 1;
    logic              cmd_valid = 0, cmd_write = 0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              cmd_ready, rsp_valid, rsp_write, HSEL, HWRITE, HREADY;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] rsp_rdata, HWDATA, HRDATA;
    logic              cmd_ready0, rsp_valid0, rsp_write0, HSEL0, HWRITE0, HREADY0;
    logic [ADDR_W-1:0] HADDR0;
    logic [DATA_W-1:0] rsp_rdata0, HWDATA0;
    logic              ready = 1, stall_en = 0, stall_bit = 0, HREADYOUT;

    int tests = 0, fails = 0;
    logic [DATA_W:0] exp_q[$];

    always #5 HCLK = ~HCLK;

    assign HREADYOUT = ready && !(stall_en && stall_bit);

    ahb_cmd_master #(.FIFO_DEPTH(4), .PIPELINE(1)) u_dut (
        .HCLK(HCLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
    );

    ahb_cmd_master #(.FIFO_DEPTH(4), .PIPELINE(0)) u_dut0 (
        .HCLK(HCLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid0), .rsp_write(rsp_write0), .rsp_rdata(rsp_rdata0),
        .HSEL(HSEL0), .HADDR(HADDR0), .HWRITE(HWRITE0), .HREADY(HREADY0), .HWDATA(HWDATA0),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
    );

    // slave memory behind the bridge, driven by the PIPELINE=1 master
    logic [DATA_W-1:0] smem [128] = '{default: '0};
    logic              s_dp = 0, s_wr = 0;
    logic [ADDR_W-1:0] s_addr = '0;

    assign HRDATA = (s_dp && !s_wr) ? smem[s_addr] : '0;

    always @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            s_dp <= 0;
        end else begin
            stall_bit <= ($urandom_range(0, 2) == 0);
            if (s_dp && HREADYOUT && s_wr) smem[s_addr] <= HWDATA;
            if (HSEL && HREADYOUT) begin
                s_dp   <= 1;
                s_addr <= HADDR;
                s_wr   <= HWRITE;
            end else if (s_dp && HREADYOUT) begin
                s_dp <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: every response pulse pops the oldest expectation
    always @(negedge HCLK) begin
        if (!RESET && rsp_valid) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            else chk("rsp", 64'({rsp_write, rsp_rdata}), 64'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] exp_rd);
        logic rdy, ok;
        ok = 0;
        cmd_valid = 1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            rdy = cmd_ready;
            @(posedge HCLK);
            if (rdy) ok = 1;
            #1;
        end
        cmd_valid = 0;
        if (ok) exp_q.push_back({w, w ? 32'h0 : exp_rd});
        else chk("push_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge HCLK);
        repeat (3) @(posedge HCLK);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        RESET = 1;
        exp_q.delete();
        repeat (2) @(negedge HCLK);
        RESET = 0;
        #1;
    endtask

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;
    vec_t tbl[8];
    logic hs1[5], hs0[5], rv1[5];

    initial begin
        tbl[0] = '{1'b1, 7'h03, 32'h1234_5678, 32'h0};
        tbl[1] = '{1'b1, 7'h21, 32'hA5A5_5A5A, 32'h0};
        tbl[2] = '{1'b1, 7'h7F, 32'hFFFF_FFFF, 32'h0};
        tbl[3] = '{1'b0, 7'h03, 32'h0,         32'h1234_5678};
        tbl[4] = '{1'b1, 7'h40, 32'hCAFE_F00D, 32'h0};
        tbl[5] = '{1'b0, 7'h7F, 32'h0,         32'hFFFF_FFFF};
        tbl[6] = '{1'b0, 7'h21, 32'h0,         32'hA5A5_5A5A};
        tbl[7] = '{1'b0, 7'h40, 32'h0,         32'hCAFE_F00D};

        repeat (3) @(negedge HCLK);
        RESET = 0;
        #1;
        chk("rst_hsel", 64'(HSEL), 0);
        chk("rst_haddr", 64'(HADDR), 0);
        chk("rst_hwdata", 64'(HWDATA), 0);
        chk("rst_rsp", 64'({rsp_valid, rsp_write, rsp_rdata}), 0);
        chk("rst_ready", 64'(cmd_ready), 1);

        // single write with a stalled data phase
        send(1, 7'h25, 32'hDEADBEEF, 0);
        chk("wr_addr_phase", 64'({HSEL, HWRITE, HADDR}), 64'({1'b1, 1'b1, 7'h25}));
        chk("wr_psel", 64'(4'b1 << HADDR[PSEL_HI:PSEL_LO]), 64'(4'b0010));
        chk("wr_paddr", 64'(HADDR[PADDR_HI:PADDR_LO]), 64'(5'h05));
        @(posedge HCLK);
        #1;
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_hwdata_hold", 64'(HWDATA), 64'(32'hDEADBEEF));
            chk("wr_no_rsp", 64'(rsp_valid), 0);
            @(posedge HCLK);
            #1;
        end
        ready = 1;
        wait_idle();

        send(0, 7'h25, 0, 32'hDEADBEEF);
        wait_idle();

        // vector table with random bridge stalls
        stall_en = 1;
        foreach (tbl[i]) send(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd);
        wait_idle();
        stall_en = 0;

        // FIFO full while the bridge stalls the first address phase
        ready = 0;
        for (int i = 0; i < 4; i++) send(1, 7'(8'h10 + i), 32'(32'h100 + i), 0);
        chk("full_ready", 64'(cmd_ready), 0);
        cmd_valid = 1;
        cmd_write = 1;
        cmd_addr  = 7'h14;
        cmd_wdata = 32'h104;
        for (int i = 0; i < 3; i++) begin
            chk("full_hold", 64'({HSEL, HADDR, cmd_ready}), 64'({1'b1, 7'h10, 1'b0}));
            @(posedge HCLK);
            #1;
        end
        ready = 1;
        send(1, 7'h14, 32'h104, 0);
        wait_idle();
        for (int i = 0; i < 5; i++) chk("full_data", 64'(smem[8'h10 + i]), 64'(32'h100 + i));

        // pipelined vs. idle-separated issue of three preloaded writes
        do_reset();
        ready = 0;
        for (int i = 0; i < 3; i++) send(1, 7'(8'h50 + i), 32'(32'h500 + i), 0);
        ready = 1;
        for (int i = 0; i < 5; i++) begin
            hs1[i] = HSEL;
            hs0[i] = HSEL0;
            rv1[i] = rsp_valid;
            @(posedge HCLK);
            #1;
        end
        chk("pipe1_hsel", 64'({hs1[0], hs1[1], hs1[2], hs1[3], hs1[4]}), 64'(5'b11100));
        chk("pipe0_hsel", 64'({hs0[0], hs0[1], hs0[2], hs0[3], hs0[4]}), 64'(5'b10101));
        chk("pipe1_rsp", 64'({rv1[0], rv1[1], rv1[2], rv1[3], rv1[4]}), 64'(5'b00111));
        wait_idle();

        // reset during a stalled write data phase
        do_reset();
        send(1, 7'h33, 32'h1111_1111, 0);
        @(posedge HCLK);
        #1;
        ready = 0;
        chk("mid_dp", 64'(HWDATA), 64'(32'h1111_1111));
        #2;
        RESET = 1;
        exp_q.delete();
        #1;
        chk("mid_rst_bus", 64'({HSEL, HWRITE, HADDR, HWDATA, rsp_valid}), 0);
        @(negedge HCLK);
        RESET = 0;
        ready = 1;
        #1;
        chk("mid_rst_ready", 64'(cmd_ready), 1);
        repeat (4) @(posedge HCLK);
        #1;
        chk("mid_rst_empty", 64'(HSEL), 0);
        chk("mid_rst_nowrite", 64'(smem[7'h33]), 0);
        send(0, 7'h25, 0, 32'hDEADBEEF);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
